if_stage_fetch: RTL
===================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline. It produces the instruction word that the ID-stage control decoder consumes, and it acts on the stall and if_id_flush signals that the ID stage sends back.
- Contents: PC register, word-addressed instruction memory with a program-load write port, and the IF/ID pipeline register.
- On a taken BEQ flush: redirects the PC to the branch target and squashes the wrong-path instruction into a NOP bubble.

Parameters:
IMEM_DEPTH, 256, number of 32-bit instruction words; must be a power of two
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  load-use hazard hold: freeze PC and IF/ID register
if_id_flush  in  1  taken branch resolved in ID: redirect PC, bubble IF/ID
branch_target  in  32  branch destination PC, valid when if_id_flush=1
imem_we  in  1  program-load write enable
imem_waddr  in  $clog2(IMEM_DEPTH)  program-load word address
imem_wdata  in  32  program-load instruction word
pc  out  32  current fetch PC
if_id_instr  out  32  IF/ID instruction to the ID-stage decoder
if_id_pc  out  32  PC of if_id_instr
if_id_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (rst=1 at clock edge):
  - pc <= RESET_PC.
  - if_id_instr <= NOP_INSTR (32'h0000_0013, addi x0,x0,0).
  - if_id_pc <= 0.
  - if_id_valid <= 0.
  - Instruction memory contents are not cleared.
- Reset mid-operation: rst wins over stall, flush and normal fetch. An imem write in the same cycle still commits.
- Fetch read is combinational: fetch_word = mem[pc[2+:log2(IMEM_DEPTH)]].
  - If pc >= 4*IMEM_DEPTH, fetch_word = NOP_INSTR.
- Priority per cycle is rst > if_id_flush > stall > normal.
- Normal (no stall, no flush):
  - if_id_instr <= fetch_word.
  - if_id_pc <= pc.
  - if_id_valid <= 1.
  - pc <= pc + 4.
- Stall=1 (flush=0): pc, if_id_instr, if_id_pc and if_id_valid all hold.
- if_id_flush=1:
  - pc <= {branch_target[31:2], 2'b00}; the low two bits are forced to zero.
  - if_id_instr <= NOP_INSTR.
  - if_id_valid <= 0.
  - if_id_pc <= 0.
  - Flush wins even if stall=1 in the same cycle. The decoder never raises both, but the RTL must define the result.
- Latency: the instruction at PC p appears on if_id_instr exactly one cycle after pc=p with no stall. The first real instruction is visible in the second cycle after rst deasserts.
- PC arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
- Program-load writes:
  - A write commits at the clock edge.
  - A fetch from the same address in the same cycle returns the old word.
  - The new word is visible from the next cycle.
- Writes are legal at any time, including during stall or flush.
- No X may propagate to any output after reset.

Decomposition:
- cpu_pkg additions:
  - constant NOP_INSTR = 32'h0000_0013.
  - typedef if_id_t: struct packed { logic [31:0] instr; logic [31:0] pc; logic valid; }, used internally for the IF/ID register.
- One sub-module, instr_mem: register-array storage with synchronous write and combinational read. Parameters: IMEM_DEPTH. Ports: clk, we, waddr, wdata, raddr, rdata.
- The out-of-range check on PC stays in if_stage_fetch.

Test Plan:
1. Load mem[0..3] = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F, then release rst with no stall or flush -> pc steps 0,4,8,12. if_id_instr presents 00500093 then 00A00113, one cycle behind, with valid=1.
2. Assert stall for 2 cycles while pc=8 -> pc stays 8 and if_id_instr stays 00A00113 for both cycles. After release, 002081B3 appears on the next cycle.
3. With pc=12, assert if_id_flush=1 and branch_target=32'h0000_0006 -> next cycle pc=4, if_id_instr=32'h00000013, valid=0. The cycle after that, if_id_instr=00A00113.
4. Assert if_id_flush=1 and stall=1 together with branch_target=0 -> flush wins: pc=0 and a bubble is inserted.
5. Set pc to 4*IMEM_DEPTH via flush (target 32'h400 with depth 256) -> if_id_instr=NOP_INSTR with valid=1. Separately, flush to 32'hFFFF_FFFC and run one more cycle -> pc wraps to 0.
6. imem write to address 1 in the same cycle pc=4 is fetched -> IF/ID receives the old word and the new word is fetched on the next visit. Assert rst mid-stream while stall=1 -> pc=RESET_PC, valid=0, if_id_instr=NOP_INSTR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline constants and types.
// The IF stage uses these for its NOP bubble and its IF/ID register layout.
package cpu_pkg;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction store.
// Writes are synchronous; reads are combinational, so a read in the same cycle as a write returns the old word.
module instr_mem #(
   parameter int unsigned IMEM_DEPTH = 256,
   localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [IMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, instruction memory and the IF/ID register.
// Handles load-use stalls and taken-branch flushes coming back from ID.
module if_stage_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          if_id_flush,
   input  logic [31:0]   branch_target,
   input  logic          imem_we,
   input  logic [AW-1:0] imem_waddr,
   input  logic [31:0]   imem_wdata,
   output logic [31:0]   pc,
   output logic [31:0]   if_id_instr,
   output logic [31:0]   if_id_pc,
   output logic          if_id_valid
);

   logic [31:0] r_pc;
   if_id_t      r_if_id;
   logic [31:0] w_rdata;
   logic [31:0] w_fetch_word;
   logic        w_in_range;
   logic        w_unused_target;

   instr_mem #(
      .IMEM_DEPTH(IMEM_DEPTH)
   ) u_instr_mem (
      .clk  (clk),
      .we   (imem_we),
      .waddr(imem_waddr),
      .wdata(imem_wdata),
      .raddr(r_pc[AW+1:2]),
      .rdata(w_rdata)
   );

   // Addresses past the end of memory fetch a NOP rather than an aliased word.
   assign w_in_range   = (r_pc[31:AW+2] == '0);
   assign w_fetch_word = w_in_range ? w_rdata : NOP_INSTR;

   // Branch targets are forced word-aligned, so the low bits are ignored.
   assign w_unused_target = ^branch_target[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_if_id <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
      end else if (if_id_flush) begin
         r_pc    <= {branch_target[31:2], 2'b00};
         r_if_id <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
      end else if (!stall) begin
         r_pc    <= r_pc + 32'd4;
         r_if_id <= '{instr: w_fetch_word, pc: r_pc, valid: 1'b1};
      end
   end

   assign pc          = r_pc;
   assign if_id_instr = r_if_id.instr;
   assign if_id_pc    = r_if_id.pc;
   assign if_id_valid = r_if_id.valid;

endmodule
